// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped I/O controller.
// Holds the I/O window register offsets, the STATUS bit map, the CTRL bit map
// and the window-hit helper used by the top level.
package io_pkg;

    // Register offsets inside the 4-word I/O window
    localparam logic [1:0] IO_DATA   = 2'd0;
    localparam logic [1:0] IO_STATUS = 2'd1;
    localparam logic [1:0] IO_CTRL   = 2'd2;
    localparam logic [1:0] IO_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NE     = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_ERR_RX    = 2;
    localparam int ST_ERR_TX    = 3;
    localparam int ST_IRQ       = 4;
    localparam int ST_RXCNT_LSB = 8;
    localparam int ST_TXCNT_LSB = 12;

    // CTRL bit positions
    localparam int CTRL_CLR_ERR = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_FLUSH   = 2;

    // Word-aligned window compare: caller passes address and base bits [15:2]
    function automatic logic win_hit(input logic [13:0] addr_hi, input logic [13:0] base_hi);
        return (addr_hi == base_hi);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: 16-bit synchronous FIFO used for both the RX and TX streams.
// Ports: clk, reset (async active-low), push/pop requests (ignored when
// full/empty respectively, judged on the state before the update), flush
// (empties the FIFO and overrides push/pop), din, dout (head word),
// full, empty, count (0..DEPTH).
module io_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty,
    output logic [3:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [3:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == 4'(DEPTH));
    assign empty  = (count_r == 4'd0);
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage, pointers and occupancy; flush beats any concurrent push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O controller on the CPU memory port.
// Accesses inside the 4-word window at IO_BASE reach the RX/TX FIFOs and the
// STATUS/CTRL registers; every other address passes through to RAM.
// Read data returns on cpu_rdata one cycle after the access and holds after.
// Ports: clk, reset (async active-low), mem_addr/mem_wdata/mem_rd/mem_wr (CPU),
// cpu_rdata (to datapath), ram_rd/ram_wr/ram_rdata (RAM side),
// rx_data/rx_valid/rx_ready (inbound), tx_data/tx_valid/tx_ready (outbound),
// irq (only when MMIO_IRQ_EN is defined).
// Build option: define MMIO_IRQ_EN to add the interrupt output and irq_en bit.
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [15:0] cpu_rdata,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [15:0] ram_rdata,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        hit_s;
    logic [1:0]  off_s;
    logic        data_rd_s;
    logic        data_wr_s;
    logic        ctrl_wr_s;
    logic        clr_s;
    logic        flush_s;
    logic        rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
    logic [3:0]  rx_count_s, tx_count_s;
    logic [15:0] rx_dout_s;
    logic [15:0] status_s;
    logic [15:0] io_rval_s;
    logic [15:0] cpu_rdata_s;
    logic        irq_bit_s;

    logic        err_rx_r;
    logic        err_tx_r;
    logic        rd_pend_r;
    logic        io_hit_r;
    logic [15:0] io_rdata_r;
    logic [15:0] hold_r;

    assign hit_s     = win_hit(mem_addr[15:2], IO_BASE[15:2]);
    assign off_s     = mem_addr[1:0];
    assign data_rd_s = hit_s && mem_rd && (off_s == IO_DATA);
    assign data_wr_s = hit_s && mem_wr && (off_s == IO_DATA);
    assign ctrl_wr_s = hit_s && mem_wr && (off_s == IO_CTRL);
    assign clr_s     = ctrl_wr_s && mem_wdata[CTRL_CLR_ERR];
    assign flush_s   = ctrl_wr_s && mem_wdata[CTRL_FLUSH];

    assign ram_rd    = mem_rd && !hit_s;
    assign ram_wr    = mem_wr && !hit_s;
    assign rx_ready  = !rx_full_s;
    assign tx_valid  = !tx_empty_s;
    assign cpu_rdata = cpu_rdata_s;

    io_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (data_rd_s),
        .flush (flush_s),
        .din   (rx_data),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    io_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr_s),
        .pop   (tx_ready),
        .flush (flush_s),
        .din   (mem_wdata),
        .dout  (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

`ifdef MMIO_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    assign irq       = irq_r;
    assign irq_bit_s = irq_r;

    // Interrupt enable and level interrupt, one cycle behind its cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                irq_en_r <= mem_wdata[CTRL_IRQ_EN];
            end
            irq_r <= irq_en_r && (!rx_empty_s || err_rx_r || err_tx_r);
        end
    end
`else
    assign irq_bit_s = 1'b0;
`endif

    // STATUS word assembly
    always_comb begin
        status_s                       = 16'h0000;
        status_s[ST_RX_NE]             = !rx_empty_s;
        status_s[ST_TX_FULL]           = tx_full_s;
        status_s[ST_ERR_RX]            = err_rx_r;
        status_s[ST_ERR_TX]            = err_tx_r;
        status_s[ST_IRQ]               = irq_bit_s;
        status_s[ST_RXCNT_LSB +: 4]    = rx_count_s;
        status_s[ST_TXCNT_LSB +: 4]    = tx_count_s;
    end

    // I/O read value selected by window offset
    always_comb begin
        io_rval_s = 16'h0000;
        case (off_s)
            IO_DATA:   io_rval_s = rx_empty_s ? 16'h0000 : rx_dout_s;
            IO_STATUS: io_rval_s = status_s;
`ifdef MMIO_IRQ_EN
            IO_CTRL:   io_rval_s = {14'h0000, irq_en_r, 1'b0};
`else
            IO_CTRL:   io_rval_s = 16'h0000;
`endif
            default:   io_rval_s = 16'h0000;
        endcase
    end

    // Sticky error flags; a new error in the same cycle as a clear stays set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_rx_r <= 1'b0;
            err_tx_r <= 1'b0;
        end else begin
            err_rx_r <= (data_rd_s && rx_empty_s) ? 1'b1 : (clr_s ? 1'b0 : err_rx_r);
            err_tx_r <= (data_wr_s && tx_full_s)  ? 1'b1 : (clr_s ? 1'b0 : err_tx_r);
        end
    end

    // Read path: capture hit flag and I/O value on the access, hold after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_r  <= 1'b0;
            io_hit_r   <= 1'b0;
            io_rdata_r <= 16'h0000;
            hold_r     <= 16'h0000;
        end else begin
            rd_pend_r <= mem_rd;
            if (mem_rd) begin
                io_hit_r   <= hit_s;
                io_rdata_r <= io_rval_s;
            end
            if (rd_pend_r) begin
                hold_r <= cpu_rdata_s;
            end
        end
    end

    // RAM data arrives a cycle after ram_rd, so it is muxed in live
    always_comb begin
        if (rd_pend_r) begin
            cpu_rdata_s = io_hit_r ? io_rdata_r : ram_rdata;
        end else begin
            cpu_rdata_s = hold_r;
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] IO_BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [15:0] cpu_rdata;
    logic        ram_rd, ram_wr;
    logic [15:0] ram_rdata = 16'h0000;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_ready;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] rxq[$];
    logic [15:0] txq[$];
    logic [15:0] dut_sent[$];
    logic [15:0] ref_ram [256];
    logic        m_err_rx, m_err_tx, m_irq_en, m_irq;
    logic [15:0] m_last;

    // simple RAM hanging off the pass-through strobes
    logic [15:0] ram_mem [256];

    mmio_io_ctrl #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .cpu_rdata(cpu_rdata), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_rdata(ram_rdata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef MMIO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 16'h0000;
            ram_rdata <= 16'h0000;
        end else begin
            if (ram_rd) ram_rdata <= ram_mem[mem_addr[7:0]];
            if (ram_wr) ram_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete(); txq.delete();
        m_err_rx = 1'b0; m_err_tx = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
        m_last = 16'h0000;
        for (int i = 0; i < 256; i++) ref_ram[i] = 16'h0000;
    endtask

    // One CPU/stream cycle: drive, check combinational view, clock, check results
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic rxv,
                        input logic [15:0] rxd, input logic txr);
        logic       hit, flush, clr, nirq;
        logic [1:0] off;
        logic [15:0] rv;
        int rxn, txn;
        mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        #1;
        hit = (addr >= IO_BASE) && (addr <= IO_BASE + 16'd3);
        off = 2'(addr - IO_BASE);
        rxn = rxq.size();
        txn = txq.size();
        chk("ram_rd", {15'h0, ram_rd}, {15'h0, rd && !hit});
        chk("ram_wr", {15'h0, ram_wr}, {15'h0, wr && !hit});
        chk("rx_ready", {15'h0, rx_ready}, {15'h0, rxn < DEPTH});
        chk("tx_valid", {15'h0, tx_valid}, {15'h0, txn > 0});
        if (txn > 0) chk("tx_data", tx_data, txq[0]);
        if (tx_valid && txr) dut_sent.push_back(tx_data);

        rv = 16'h0000;
        if (!hit) rv = ref_ram[addr[7:0]];
        else if (off == 2'd0) rv = (rxn > 0) ? rxq[0] : 16'h0000;
        else if (off == 2'd1)
            rv = 16'(txn * 4096 + rxn * 256 + int'(m_irq) * 16 + int'(m_err_tx) * 8
                     + int'(m_err_rx) * 4 + int'(txn == DEPTH) * 2 + int'(rxn > 0));
`ifdef MMIO_IRQ_EN
        else if (off == 2'd2) rv = m_irq_en ? 16'h0002 : 16'h0000;
`endif
        nirq  = m_irq_en && (rxn > 0 || m_err_rx || m_err_tx);
        flush = hit && wr && off == 2'd2 && wdata[2];
        clr   = hit && wr && off == 2'd2 && wdata[0];
`ifdef MMIO_IRQ_EN
        if (hit && wr && off == 2'd2) m_irq_en = wdata[1];
`endif
        if (hit && rd && off == 2'd0 && rxn == 0) m_err_rx = 1'b1;
        else if (clr) m_err_rx = 1'b0;
        if (hit && wr && off == 2'd0 && txn == DEPTH) m_err_tx = 1'b1;
        else if (clr) m_err_tx = 1'b0;
        if (flush) begin
            rxq.delete(); txq.delete();
        end else begin
            if (hit && rd && off == 2'd0 && rxn > 0) void'(rxq.pop_front());
            if (rxv && rxn < DEPTH) rxq.push_back(rxd);
            if (txr && txn > 0) void'(txq.pop_front());
            if (hit && wr && off == 2'd0 && txn < DEPTH) txq.push_back(wdata);
        end
        if (!hit && wr) ref_ram[addr[7:0]] = wdata;

        @(posedge clk);
        #1;
        m_irq = nirq;
        if (rd) m_last = rv;
        chk("cpu_rdata", cpu_rdata, m_last);
`ifdef MMIO_IRQ_EN
        chk("irq", {15'h0, irq}, {15'h0, m_irq});
`endif
    endtask

    task automatic idle(input logic txr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, txr);
    endtask

    localparam logic [15:0] A_DATA = IO_BASE;
    localparam logic [15:0] A_STAT = IO_BASE + 16'd1;
    localparam logic [15:0] A_CTRL = IO_BASE + 16'd2;

    initial begin
        logic [15:0] rxw [4];
        rxw[0] = 16'h1111; rxw[1] = 16'h2222; rxw[2] = 16'h3333; rxw[3] = 16'h4444;
        reset = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        rx_valid = 1'b0; rx_data = 16'h0000; tx_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("rst_rx_ready", {15'h0, rx_ready}, 16'h0001);
        chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // RAM pass-through
        step(1'b0, 1'b1, 16'h0010, 16'h00AA, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0, 1'b0);
        chk("ram_readback", cpu_rdata, 16'h00AA);

        // RX fill and drain
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, rxw[i], 1'b0);
        chk("rx_ready_full", {15'h0, rx_ready}, 16'h0000);
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_rx4", cpu_rdata, 16'h0401);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, A_DATA, 16'h0, 1'b0, 16'h0, 1'b0);
            chk("rx_order", cpu_rdata, rxw[i]);
        end
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_rx0", cpu_rdata, 16'h0000);

        // TX overflow then drain
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, A_DATA, 16'hA000 + 16'(i), 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_txfull", cpu_rdata, 16'h400A);
        step(1'b0, 1'b1, A_CTRL, 16'h0001, 1'b0, 16'h0, 1'b0);
        dut_sent.delete();
        idle(1'b1, 6);
        chk("tx_sent_cnt", 16'(dut_sent.size()), 16'd4);
        for (int i = 0; i < 4; i++)
            if (i < dut_sent.size()) chk("tx_sent_word", dut_sent[i], 16'hA000 + 16'(i));

        // RX-empty error and clear
        step(1'b1, 1'b0, A_DATA, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("rx_empty_read", cpu_rdata, 16'h0000);
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_err_rx", cpu_rdata, 16'h0004);
        step(1'b0, 1'b1, A_CTRL, 16'h0001, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_cleared", cpu_rdata, 16'h0000);

        // Flush both FIFOs
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, A_DATA, 16'hC000 + 16'(i), 1'b1, 16'hD000 + 16'(i), 1'b0);
        end
        step(1'b0, 1'b1, A_CTRL, 16'h0004, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, A_STAT, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("status_flushed", cpu_rdata, 16'h0000);
        chk("flush_tx_valid", {15'h0, tx_valid}, 16'h0000);
        chk("flush_rx_ready", {15'h0, rx_ready}, 16'h0001);

        // Reset in the middle of traffic
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
        step(1'b0, 1'b1, A_DATA, 16'h5A5A, 1'b1, 16'h1234, 1'b0);
        step(1'b1, 1'b0, A_DATA, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("pre_rst_read", cpu_rdata, 16'hBEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("midrst_rx_ready", {15'h0, rx_ready}, 16'h0001);
        chk("midrst_tx_valid", {15'h0, tx_valid}, 16'h0000);
`ifdef MMIO_IRQ_EN
        chk("midrst_irq", {15'h0, irq}, 16'h0000);
`endif
        mem_rd = 1'b0; mem_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifdef MMIO_IRQ_EN
        // Interrupt on RX data
        step(1'b0, 1'b1, A_CTRL, 16'h0002, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h7777, 1'b0);
        chk("irq_not_yet", {15'h0, irq}, 16'h0000);
        idle(1'b0, 1);
        chk("irq_rise", {15'h0, irq}, 16'h0001);
        step(1'b1, 1'b0, A_DATA, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("irq_still", {15'h0, irq}, 16'h0001);
        idle(1'b0, 1);
        chk("irq_fall", {15'h0, irq}, 16'h0000);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int          op;
            logic [15:0] a, d;
            logic        rv_s, tr_s;
            op   = int'($urandom_range(0, 9));
            d    = 16'($urandom);
            rv_s = 1'($urandom);
            tr_s = 1'($urandom);
            a    = IO_BASE + 16'($urandom_range(0, 3));
            case (op)
                0, 1, 2: step(1'b1, 1'b0, a, 16'h0, rv_s, d, tr_s);
                3, 4:    step(1'b0, 1'b1, A_DATA, d, rv_s, 16'($urandom), tr_s);
                5:       step(1'b0, 1'b1, A_CTRL,
                              {d[15:3], ($urandom_range(0, 7) == 0), d[1:0]},
                              rv_s, 16'($urandom), tr_s);
                6:       step(1'b0, 1'b1, IO_BASE + 16'(1 + 2 * int'(d[0])), d, rv_s, d, tr_s);
                7:       step(1'b0, 1'b1, 16'($urandom_range(0, 15)), d, rv_s, d, tr_s);
                8:       step(1'b1, 1'b0, 16'($urandom_range(0, 15)), 16'h0, rv_s, d, tr_s);
                default: step(1'b0, 1'b0, 16'h0, 16'h0, rv_s, d, tr_s);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Memory-mapped I/O controller on the CPU memory port, between the datapath's address/write-data outputs and its `data_in` input. Decodes each CPU access: the I/O window goes to an RX FIFO, a TX FIFO and status/control registers; all other addresses pass through to RAM. Read data returns on `cpu_rdata` one cycle after the access, whether it targets RAM or I/O. External devices attach through valid/ready streams.

## Interface
- `DEPTH`, default 4: entries per FIFO; power of two, 2–8.
- `IO_BASE`, default 16'hFF00: base of the 4-word I/O window; bits [1:0] must be 0.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `mem_addr`  in  16  CPU address
- `mem_wdata`  in  16  CPU write data (datapath `data_out`)
- `mem_rd`  in  1  read strobe, one cycle per access
- `mem_wr`  in  1  write strobe, one cycle per access; never asserted together with `mem_rd`
- `cpu_rdata`  out  16  read data to datapath `data_in`
- `ram_rd` / `ram_wr`  out  1  gated strobes to RAM (addr/wdata wired through)
- `ram_rdata`  in  16  RAM read data, valid one cycle after `ram_rd`
- `rx_data`  in  16 / `rx_valid`  in  1 / `rx_ready`  out  1  inbound stream
- `tx_data`  out  16 / `tx_valid`  out  1 / `tx_ready`  in  1  outbound stream
- `irq`  out  1  interrupt, present only with `MMIO_IRQ_EN`

## Operation
- Window hit: `mem_addr[15:2] == IO_BASE[15:2]`. On a hit, `ram_rd`/`ram_wr` = 0. On a miss, they equal `mem_rd`/`mem_wr`.
- Offset 0, DATA:
  - Read pops the RX head. If RX is empty, the read returns 0 and sets `err_rx_empty`.
  - Write pushes to TX. If TX is full, the write is dropped and sets `err_tx_full`.
- Offset 1, STATUS (read-only; writes ignored):
  - [0] RX not empty; [1] TX full.
  - [2] `err_rx_empty`; [3] `err_tx_full`.
  - [4] irq pending; [7:5] 0.
  - [11:8] RX count; [15:12] TX count.
- Offset 2, CTRL:
  - Write bit0 = 1: clears both error flags.
  - Write bit1: sets `irq_en`.
  - Write bit2 = 1: flushes both FIFOs (pointers and counts to 0).
  - Read returns {14'b0, `irq_en`, 1'b0}.
- Offset 3: reserved; reads 0, writes ignored.
- Inbound: `rx_ready` = RX not full; push on `rx_valid && rx_ready`.
- Outbound: `tx_valid` = TX not empty; `tx_data` = TX head; pop on `tx_valid && tx_ready`.
- Simultaneous events:
  - CPU pop and external push in the same cycle: both happen; the count is unchanged when RX was non-empty.
  - CPU pop with RX empty and an external push in the same cycle: the pop reads 0 and flags the error; the push is stored.
  - CPU push and external pop on TX when full: the external pop happens; the CPU push is still dropped, because fullness is evaluated before the update.
  - Flush in the same cycle as a push or pop: flush wins; the FIFO ends empty.
  - Error-clear in the same cycle as a new error event: the set wins.
- FIFO pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. Counts are 4 bits wide, range 0..`DEPTH`.

## Timing
- Read latency is 1 cycle for every address.
- The block registers a hit/miss flag and the I/O read value on the access cycle.
- The next cycle, `cpu_rdata` = registered I/O value when that flag is set, else `ram_rdata`.
- Between reads, `cpu_rdata` holds its last value.
- An RX pop takes effect at the end of the access cycle; a STATUS read on the next cycle shows the new count.
- Reset (asynchronous assert, synchronous release) initialises:
  - both FIFOs empty;
  - error flags, `irq_en` and the registered read value to 0;
  - `cpu_rdata` = 0, `rx_ready` = 1, `tx_valid` = 0, `irq` = 0.
- Reset mid-access aborts the access; FIFO contents are discarded.

## Configuration
- `MMIO_IRQ_EN` defined:
  - `irq` port exists.
  - `irq` = registered `irq_en && (RX not empty || err_rx_empty || err_tx_full)`, asserted one cycle after its cause.
  - It is level-sensitive and deasserts one cycle after the cause clears.
  - STATUS[4] mirrors `irq`.
- `MMIO_IRQ_EN` undefined:
  - no `irq` port; STATUS[4] reads 0.
  - CTRL bit1 is ignored; the CTRL read value is always 0.

## Structure
- Package `io_pkg`:
  - offset constants `IO_DATA`, `IO_STATUS`, `IO_CTRL`;
  - STATUS bit-position constants;
  - CTRL bit-position constants.
- Sub-module `io_fifo` (parameter `DEPTH`):
  - ports `push`, `pop`, `flush`, `din`, `dout`, `full`, `empty`, `count`;
  - instantiated twice, once for RX and once for TX.

## Test plan
- Reset, then write 16'h00AA to RAM address 16'h0010 and read it back: `ram_wr` pulses, `cpu_rdata` = 16'h00AA one cycle after the read, `ram_rd`/`ram_wr` stay 0 for all window accesses.
- External pushes 16'h1111, 16'h2222, 16'h3333, 16'h4444 (`DEPTH`=4): `rx_ready` drops after the fourth push; STATUS = 16'h0401; four DATA reads return them in order; STATUS = 16'h0000.
- Five CPU writes to DATA with `tx_ready`=0: STATUS[1]=1 and STATUS[3]=1; then raise `tx_ready`: exactly four words leave, in order, with the fifth dropped.
- DATA read with RX empty returns 0 and sets STATUS[2]; CTRL write 16'h0001 clears it; simultaneous error and clear leaves the flag at 1.
- Fill both FIFOs, write CTRL 16'h0004: next STATUS read = 16'h0000, `tx_valid`=0, `rx_ready`=1; assert `reset` low mid-stream: all outputs reach their reset values immediately.
- With `MMIO_IRQ_EN`: CTRL = 16'h0002, one external push: `irq` rises 1 cycle later and falls 1 cycle after the DATA read empties RX.
